// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master (CPU, DMA) arbiter for a shared 16-bit memory/IO port.
// The grant is combinational from the current requests and the registered owner
// state. Reads return one cycle after the grant; writes return nothing.
// The optional DMA anti-starvation counter is enabled by defining the macro
// DBUS_ARB_STARVE_EN. In the default build the CPU has strict priority.
module dbus_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_req,
    input  logic        dma_req,
    input  logic [1:0]  cpu_we,
    input  logic [1:0]  dma_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] dma_addr,
    input  logic [15:0] cpu_wdata,
    input  logic [15:0] dma_wdata,
    input  logic        dma_lock,
    output logic        cpu_gnt,
    output logic        dma_gnt,
    output logic        cpu_rvalid,
    output logic        dma_rvalid,
    output logic [15:0] cpu_rdata,
    output logic [15:0] dma_rdata,
    output logic [15:0] bus_addr,
    output logic [1:0]  bus_we,
    output logic [15:0] bus_wdata,
    output logic        bus_rd,
    input  logic [15:0] bus_rdata
);

    localparam int unsigned DATA_W = 16;

    // The wait counter is 3 bits wide, so the limit must fit in 1..7.
    if (STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_limit
        $error("dbus_arbiter: STARVE_LIMIT must be in 1..7");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DMA  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic cpu_win;
    logic dma_win;
    logic dma_force;
    logic starve_hit;

    // Read-return tracking: one flag per master, set for the cycle after a read grant.
    logic cpu_rd_vld_p1;
    logic dma_rd_vld_p1;

`ifdef DBUS_ARB_STARVE_EN
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [2:0] wait_cnt;

    // Saturating increment of the DMA wait counter.
    function automatic logic [2:0] sat_inc(input logic [2:0] value);
        if (value >= LIMIT) begin
            return LIMIT;
        end
        return value + 3'd1;
    endfunction

    // Count cycles DMA is kept waiting; clear on a DMA grant or when DMA stops asking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= 3'd0;
        end else if (!dma_req || dma_win) begin
            wait_cnt <= 3'd0;
        end else begin
            wait_cnt <= sat_inc(wait_cnt);
        end
    end

    assign starve_hit = (wait_cnt == LIMIT);
`else
    // Strict CPU priority: DMA is never forced ahead of the CPU by waiting.
    assign starve_hit = 1'b0;
`endif

    // DMA overrides CPU priority when it holds a lock it already owns, or has waited too long.
    assign dma_force = dma_req && (((state == ST_DMA) && dma_lock) || starve_hit);

    // ---- stage p0: arbitration and bus drive (combinational) ----

    // Owner state register: remembers who had the bus last cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next owner is whoever wins this cycle, or nobody.
    always_comb begin
        state_next = ST_IDLE;
        if (cpu_win) begin
            state_next = ST_CPU;
        end else if (dma_win) begin
            state_next = ST_DMA;
        end
    end

    // Grant decision: forced DMA first, then fixed CPU-over-DMA priority; nothing in reset.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        if (reset_n) begin
            if (dma_force) begin
                dma_win = 1'b1;
            end else if (cpu_req) begin
                cpu_win = 1'b1;
            end else if (dma_req) begin
                dma_win = 1'b1;
            end
        end
    end

    assign cpu_gnt = cpu_win;
    assign dma_gnt = dma_win;

    // Route the winning master's transaction onto the shared port; idle bus is all zero.
    always_comb begin
        bus_addr  = '0;
        bus_we    = 2'b00;
        bus_wdata = '0;
        bus_rd    = 1'b0;
        if (cpu_win) begin
            bus_addr  = cpu_addr;
            bus_we    = cpu_we;
            bus_wdata = cpu_wdata;
            bus_rd    = (cpu_we == 2'b00);
        end else if (dma_win) begin
            bus_addr  = dma_addr;
            bus_we    = dma_we;
            bus_wdata = dma_wdata;
            bus_rd    = (dma_we == 2'b00);
        end
    end

    // ---- stage p1: read data return ----

    // Remember which master issued a read so the next cycle's bus_rdata goes back to it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_vld_p1 <= 1'b0;
            dma_rd_vld_p1 <= 1'b0;
        end else begin
            cpu_rd_vld_p1 <= cpu_win && (cpu_we == 2'b00);
            dma_rd_vld_p1 <= dma_win && (dma_we == 2'b00);
        end
    end

    assign cpu_rvalid = cpu_rd_vld_p1;
    assign dma_rvalid = dma_rd_vld_p1;

    // Return data only to the owner of the pending read; zero otherwise.
    always_comb begin
        cpu_rdata = {DATA_W{1'b0}};
        dma_rdata = {DATA_W{1'b0}};
        if (cpu_rd_vld_p1) begin
            cpu_rdata = bus_rdata;
        end
        if (dma_rd_vld_p1) begin
            dma_rdata = bus_rdata;
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: directed per-cycle vectors with hand-computed
// expectations pushed into a queue; a monitor on the falling edge pops and
// compares the full output vector. Starvation expectations follow
// DBUS_ARB_STARVE_EN.
module tb_dbus_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_req = 1'b0, dma_req = 1'b0, dma_lock = 1'b0;
    logic [1:0]  cpu_we = 2'b00, dma_we = 2'b00;
    logic [15:0] cpu_addr = '0, dma_addr = '0, cpu_wdata = '0, dma_wdata = '0;
    logic [15:0] bus_rdata = '0;
    logic        cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, bus_rd;
    logic [15:0] cpu_rdata, dma_rdata, bus_addr, bus_wdata;
    logic [1:0]  bus_we;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [70:0] vec;
    } exp_t;

    exp_t exp_q[$];

    dbus_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .dma_req(dma_req),
        .cpu_we(cpu_we), .dma_we(dma_we),
        .cpu_addr(cpu_addr), .dma_addr(dma_addr),
        .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock),
        .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt),
        .cpu_rvalid(cpu_rvalid), .dma_rvalid(dma_rvalid),
        .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wdata(bus_wdata),
        .bus_rd(bus_rd), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Pack an expected output vector in the same order the monitor packs the DUT outputs.
    function automatic logic [70:0] ex(input logic cg, input logic dg,
                                       input logic [15:0] ba, input logic [1:0] bw,
                                       input logic [15:0] bwd, input logic br,
                                       input logic cv, input logic dv,
                                       input logic [15:0] crd, input logic [15:0] drd);
        return {cg, dg, ba, bw, bwd, br, cv, dv, crd, drd};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_cyc(input string nm, input logic [70:0] v);
        exp_t e;
        e.name = nm;
        e.vec  = v;
        exp_q.push_back(e);
    endtask

    task automatic cpu_set(input logic r, input logic [1:0] w, input logic [15:0] a, input logic [15:0] d);
        cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic dma_set(input logic r, input logic [1:0] w, input logic [15:0] a, input logic [15:0] d, input logic lk);
        dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d; dma_lock = lk;
    endtask

    // Monitor: compare every expected cycle against the DUT outputs mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [70:0] act;
            e = exp_q.pop_front();
            act = {cpu_gnt, dma_gnt, bus_addr, bus_we, bus_wdata, bus_rd,
                   cpu_rvalid, dma_rvalid, cpu_rdata, dma_rdata};
            checks++;
            if (act !== e.vec) begin
                errors++;
                $display("FAIL %s: got gnt c/d=%b%b addr=%h we=%b wdata=%h rd=%b rv c/d=%b%b rdata c=%h d=%h ; want gnt c/d=%b%b addr=%h we=%b wdata=%h rd=%b rv c/d=%b%b rdata c=%h d=%h",
                         e.name, act[70], act[69], act[68:53], act[52:51], act[50:35], act[34],
                         act[33], act[32], act[31:16], act[15:0],
                         e.vec[70], e.vec[69], e.vec[68:53], e.vec[52:51], e.vec[50:35], e.vec[34],
                         e.vec[33], e.vec[32], e.vec[31:16], e.vec[15:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held: requests present but nothing may be granted or driven.
        tick();
        cpu_set(1'b1, 2'b00, 16'h1000, 16'h1111);
        dma_set(1'b1, 2'b00, 16'h2010, 16'h0000, 1'b0);
        expect_cyc("reset_hold", '0);

        // First cycle after release: fixed CPU priority from IDLE.
        tick();
        reset_n = 1'b1;
        bus_rdata = 16'h5A5A;
        expect_cyc("prio_cpu", ex(1, 0, 16'h1000, 2'b00, 16'h1111, 1, 0, 0, 16'h0, 16'h0));

        // DMA read granted while the CPU read returns.
        tick();
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        bus_rdata = 16'hCAFE;
        expect_cyc("dma_rd_gnt", ex(0, 1, 16'h2010, 2'b00, 16'h0000, 1, 1, 0, 16'hCAFE, 16'h0));

        // Back-to-back DMA read; first DMA read returns BEEF.
        tick();
        dma_set(1'b1, 2'b00, 16'h2012, 16'h0000, 1'b0);
        bus_rdata = 16'hBEEF;
        expect_cyc("dma_rd_ret", ex(0, 1, 16'h2012, 2'b00, 16'h0000, 1, 0, 1, 16'h0, 16'hBEEF));

        tick();
        dma_set(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        bus_rdata = 16'h1234;
        expect_cyc("dma_rd_ret2", ex(0, 0, 16'h0, 2'b00, 16'h0, 0, 0, 1, 16'h0, 16'h1234));

        // Idle: rdata stays zero even with live bus_rdata.
        tick();
        bus_rdata = 16'h5555;
        expect_cyc("idle_zero", '0);

        // CPU write: passthrough of we/wdata, no bus_rd.
        tick();
        cpu_set(1'b1, 2'b11, 16'h3000, 16'hA5A5);
        expect_cyc("cpu_wr", ex(1, 0, 16'h3000, 2'b11, 16'hA5A5, 0, 0, 0, 16'h0, 16'h0));

        // No read return for a write.
        tick();
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        bus_rdata = 16'h7777;
        expect_cyc("wr_no_rvalid", '0);

        // DMA takes the bus with lock, then holds it against the CPU for 3 cycles.
        tick();
        dma_set(1'b1, 2'b01, 16'h4000, 16'h0101, 1'b1);
        expect_cyc("lock_gnt", ex(0, 1, 16'h4000, 2'b01, 16'h0101, 0, 0, 0, 16'h0, 16'h0));

        for (int i = 0; i < 3; i++) begin
            tick();
            cpu_set(1'b1, 2'b00, 16'h1004, 16'h0000);
            dma_set(1'b1, 2'b10, 16'h4002 + 16'(2 * i), 16'h0200 + 16'(i), 1'b1);
            expect_cyc($sformatf("lock_hold%0d", i),
                       ex(0, 1, 16'h4002 + 16'(2 * i), 2'b10, 16'h0200 + 16'(i), 0, 0, 0, 16'h0, 16'h0));
        end

        // Lock drops: CPU wins again.
        tick();
        dma_lock = 1'b0;
        expect_cyc("lock_drop", ex(1, 0, 16'h1004, 2'b00, 16'h0000, 1, 0, 0, 16'h0, 16'h0));

        // Lock is ignored when the CPU owns the bus.
        tick();
        cpu_set(1'b1, 2'b00, 16'h1006, 16'h0000);
        dma_lock = 1'b1;
        bus_rdata = 16'h9999;
        expect_cyc("lock_ign_cpu", ex(1, 0, 16'h1006, 2'b00, 16'h0000, 1, 1, 0, 16'h9999, 16'h0));

        tick();
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        dma_set(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        bus_rdata = 16'h4444;
        expect_cyc("cpu_rd_ret", ex(0, 0, 16'h0, 2'b00, 16'h0, 0, 1, 0, 16'h4444, 16'h0));

        // Both masters reading continuously from IDLE.
        for (int i = 0; i < 6; i++) begin
            logic cg, dg, cv, dv;
            tick();
            cpu_set(1'b1, 2'b00, 16'h1008, 16'h0000);
            dma_set(1'b1, 2'b00, 16'h2020, 16'h0000, 1'b0);
            bus_rdata = 16'h00F0;
`ifdef DBUS_ARB_STARVE_EN
            dg = (i == 4);
            cg = !dg;
            cv = (i >= 1) && (i <= 4);
            dv = (i == 5);
`else
            dg = 1'b0;
            cg = 1'b1;
            cv = (i >= 1);
            dv = 1'b0;
`endif
            expect_cyc($sformatf("starve_c%0d", i),
                       ex(cg, dg, dg ? 16'h2020 : 16'h1008, 2'b00, 16'h0000, 1,
                          cv, dv, cv ? 16'h00F0 : 16'h0, dv ? 16'h00F0 : 16'h0));
        end

        tick();
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        dma_set(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);
        expect_cyc("starve_tail", ex(0, 0, 16'h0, 2'b00, 16'h0, 0, 1, 0, 16'h00F0, 16'h0));

        // CPU read granted, then reset asserted in the following cycle.
        tick();
        cpu_set(1'b1, 2'b00, 16'h1010, 16'h0000);
        expect_cyc("pre_rst_rd", ex(1, 0, 16'h1010, 2'b00, 16'h0000, 1, 0, 0, 16'h0, 16'h0));

        tick();
        reset_n = 1'b0;
        bus_rdata = 16'hABCD;
        expect_cyc("rst_mid_read", '0);

        tick();
        reset_n = 1'b1;
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        expect_cyc("rst_no_rvalid", '0);

        // First grant after a mid-run reset again follows CPU priority.
        tick();
        cpu_set(1'b1, 2'b11, 16'h3100, 16'h0F0F);
        dma_set(1'b1, 2'b11, 16'h4100, 16'hF0F0, 1'b1);
        expect_cyc("post_rst_prio", ex(1, 0, 16'h3100, 2'b11, 16'h0F0F, 0, 0, 0, 16'h0, 16'h0));

        tick();
        cpu_set(1'b0, 2'b00, 16'h0000, 16'h0000);
        dma_set(1'b0, 2'b00, 16'h0000, 16'h0000, 1'b0);

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected cycles never checked, want 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
